// File: rtl/prf_read_arbiter_pkg.sv
// Shared definitions for the PRF read arbiter.
// Holds the default configuration (requester count, operands per read group,
// PRN width) and the stage-A register struct that carries one granted
// operand-read bundle from the grant cycle into the PRF read cycle.
package prf_read_arbiter_pkg;

  localparam int unsigned PKG_NUM_REQ      = 4;
  localparam int unsigned PKG_MAX_OPERANDS = 3;
  localparam int unsigned PKG_PRN_BITS     = 6;
  localparam int unsigned PKG_ID_BITS      = $clog2(PKG_NUM_REQ);
  localparam int unsigned OP_BITS          = 64;

  // Stage-A register contents. Field widths follow the package configuration,
  // so an instance of the arbiter has to keep its parameters at these values.
  typedef struct packed {
    logic                                             valid;
    logic [PKG_ID_BITS-1:0]                           id;
    logic [PKG_MAX_OPERANDS-1:0]                      enable;
    logic [PKG_MAX_OPERANDS-1:0][PKG_PRN_BITS-1:0]    prn;
  } stage_a_t;

endpackage

// File: rtl/prf_read_arbiter_rr_arbiter.sv
// Round-robin arbiter core.
// Searches the request vector starting at ptr, wrapping from N-1 back to 0,
// and returns the first active requester.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index where the search starts (highest priority this cycle)
//   grant - one-hot grant, all zero when no request is active
//   idx   - binary index of the granted requester (0 when none)
//   any   - at least one request is active
module prf_read_arbiter_rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // Priority search from ptr; N is a power of two so IW-bit addition wraps.
  always_comb begin
    cand  = '0;
    idx   = '0;
    any   = 1'b0;
    grant = '0;
    for (int k = 0; k < int'(N); k++) begin
      cand = ptr + IW'(k);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end else begin
        any = any;
      end
    end
    if (any) begin
      grant[idx] = 1'b1;
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/prf_read_arbiter.sv
// Shared PRF read-port arbiter.
// Each cycle picks at most one issue-queue requester round-robin, registers
// its operand read enables/PRNs onto the PRF read ports (stage A, t+1), then
// registers the returned PRF data as an operand bundle (stage B, t+2).
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   flush            - squash in-flight reads, no grant this cycle
//   stall            - block new grants; in-flight reads still complete
//   req_valid        - per-requester ready instruction
//   req_ready        - per-requester grant (combinational)
//   req_enable/prn   - per-requester, per-operand read enable and source PRN
//   prf_read_enable  - registered PRF read enables
//   prf_read_prn     - registered PRF read addresses
//   prf_op           - PRF read data, valid in the same cycle as prf_read_*
//   rsp_valid/id/op  - single-cycle operand bundle with owning requester id
module prf_read_arbiter
  import prf_read_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = PKG_NUM_REQ,
  parameter int unsigned MAX_OPERANDS = PKG_MAX_OPERANDS,
  parameter int unsigned PRN_BITS     = PKG_PRN_BITS,
  parameter int unsigned ID_BITS      = $clog2(NUM_REQ)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      flush,
  input  logic                                      stall,
  input  logic [NUM_REQ-1:0]                        req_valid,
  output logic [NUM_REQ-1:0]                        req_ready,
  input  logic [NUM_REQ-1:0][MAX_OPERANDS-1:0]      req_enable,
  input  logic [NUM_REQ-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] req_prn,
  output logic [MAX_OPERANDS-1:0]                   prf_read_enable,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]     prf_read_prn,
  input  logic [MAX_OPERANDS-1:0][OP_BITS-1:0]      prf_op,
  output logic                                      rsp_valid,
  output logic [ID_BITS-1:0]                        rsp_id,
  output logic [MAX_OPERANDS-1:0][OP_BITS-1:0]      rsp_op
);

  logic [NUM_REQ-1:0]                    arb_grant;
  logic [ID_BITS-1:0]                    arb_idx;
  logic                                  arb_any;
  logic                                  transfer;
  logic [ID_BITS-1:0]                    rr_ptr_q, rr_ptr_d;
  stage_a_t                              a_q, a_d;
  logic                                  rsp_valid_q, rsp_valid_d;
  logic [ID_BITS-1:0]                    rsp_id_q, rsp_id_d;
  logic [MAX_OPERANDS-1:0][OP_BITS-1:0]  rsp_op_q, rsp_op_d;

  prf_read_arbiter_rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_BITS)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Grant gating: reset, flush and stall all suppress the grant.
  always_comb begin
    if (rst_n && !flush && !stall) begin
      req_ready = arb_grant;
      transfer  = arb_any;
    end else begin
      req_ready = '0;
      transfer  = 1'b0;
    end
  end

  // Pointer moves just past the winner only when a transfer happens.
  always_comb begin
    if (transfer) begin
      rr_ptr_d = arb_idx + ID_BITS'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Stage A capture; idle cycles (including flush) drive zero read ports.
  always_comb begin
    a_d = '0;
    if (transfer) begin
      a_d.valid  = 1'b1;
      a_d.id     = arb_idx;
      a_d.enable = req_enable[arb_idx];
      a_d.prn    = req_prn[arb_idx];
    end else begin
      a_d = '0;
    end
  end

  // Stage B capture of PRF data; flush kills the bundle currently in stage A.
  always_comb begin
    rsp_valid_d = 1'b0;
    rsp_id_d    = '0;
    rsp_op_d    = '0;
    if (!flush) begin
      rsp_valid_d = a_q.valid;
      rsp_id_d    = a_q.id;
      for (int j = 0; j < int'(MAX_OPERANDS); j++) begin
        rsp_op_d[j] = a_q.enable[j] ? prf_op[j] : 64'h0;
      end
    end else begin
      rsp_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      a_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_op_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      a_q         <= a_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_op_q    <= rsp_op_d;
    end
  end

  assign prf_read_enable = a_q.enable;
  assign prf_read_prn    = a_q.prn;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_id          = rsp_id_q;
  assign rsp_op          = rsp_op_q;

endmodule

// File: doc/prf_read_arbiter.md
PRF_READ_ARBITER -- requirements
Module: prf_read_arbiter

Interface
REQ-001 Param NUM_REQ, default 4, number of issue-queue requesters (power of 2, >=2).
REQ-002 Param MAX_OPERANDS, default 3, read ports per shared PRF read group.
REQ-003 Param PRN_BITS, default 6, physical register number width.
REQ-004 Port clk  in  1  sole clock; all state updates on posedge.
REQ-005 Port rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port flush  in  1  squash all in-flight reads; no grant this cycle.
REQ-007 Port stall  in  1  block new grants; in-flight reads complete.
REQ-008 Port req_valid[NUM_REQ]  in  1  requester i has a ready instruction needing operands.
REQ-009 Port req_ready[NUM_REQ]  out  1  grant to requester i (combinational).
REQ-010 Port req_enable[NUM_REQ][MAX_OPERANDS]  in  1  operand j needs a PRF read.
REQ-011 Port req_prn[NUM_REQ][MAX_OPERANDS]  in  PRN_BITS  operand j source PRN.
REQ-012 Port prf_read_enable[MAX_OPERANDS]  out  1  registered PRF read enable.
REQ-013 Port prf_read_prn[MAX_OPERANDS]  out  PRN_BITS  registered PRF read address.
REQ-014 Port prf_op[MAX_OPERANDS]  in  64  PRF data, valid same cycle as prf_read_*.
REQ-015 Port rsp_valid  out  1  operand bundle valid.
REQ-016 Port rsp_id  out  clog2(NUM_REQ)  requester the bundle belongs to.
REQ-017 Port rsp_op[MAX_OPERANDS]  out  64  operand values.

Function
REQ-018 Grant: at most one req_ready high per cycle; none when flush or stall high.
REQ-019 Round-robin: search starts at rr_ptr, wraps NUM_REQ-1 -> 0; first req_valid wins.
REQ-020 Transfer occurs in cycle t when req_valid[i] && req_ready[i].
REQ-021 On transfer to i, rr_ptr <= (i+1) mod NUM_REQ; else rr_ptr unchanged.
REQ-022 Stage A (t+1): prf_read_enable[j] = captured req_enable[i][j]; prf_read_prn[j] = req_prn[i][j]; a_valid=1, a_id=i.
REQ-023 No transfer in t -> prf_read_enable all 0, prf_read_prn all 0 in t+1.
REQ-024 Stage B (t+2): rsp_valid=1, rsp_id=i, rsp_op[j] = prf_op[j] sampled end of t+1 if enable[j] else 64'h0.
REQ-025 Fixed latency: grant to rsp_valid exactly 2 cycles; throughput one bundle per cycle.
REQ-026 rsp_valid is a single-cycle pulse per transfer; no backpressure on response.
REQ-027 Transfer with all enables 0 still produces a response with all rsp_op 0.
REQ-028 flush in cycle t: a_valid and rsp_valid clear at t+1; prf_read_enable 0 at t+1; rr_ptr unchanged.
REQ-029 Grant in t-1 with flush in t: that bundle never produces rsp_valid.
REQ-030 stall does not affect stage A/B; requests held across stall are granted later in RR order.
REQ-031 Requester dropping req_valid without grant: no state change; no pending memory.

Reset
REQ-032 rst_n low: rr_ptr=0, a_valid=0, rsp_valid=0, rsp_id=0, all rsp_op=0, prf_read_enable=0, prf_read_prn=0, asynchronously.
REQ-033 req_ready all 0 while rst_n low; reset mid-operation discards all in-flight bundles.
REQ-034 First grant after reset release favours requester 0 on ties.

Structure
REQ-035 NUM_REQ, PRN_BITS, MAX_OPERANDS defaults and stage-register struct (valid, id, enable, prn) in shared foxtrot package.
REQ-036 One sub-module rr_arbiter (req vector, ptr -> one-hot grant, index, any); rest inline.

Verification
REQ-037 Reset then req_valid=4'b1111 held -> grants 0,1,2,3,0 on consecutive cycles; rsp_id same sequence 2 cycles later.
REQ-038 req_valid[2]=1, enable=3'b101, prn={5,9,12} -> t+1 prf_read_enable=101, prn={5,9,12}; t+2 rsp_op[1]=0, others = PRF data.
REQ-039 Grant to 1 at t, flush at t+1 -> no rsp_valid at t+2; rr_ptr=2 at t+2.
REQ-040 stall high 3 cycles with req_valid=4'b1010 -> no grants; on release grant 1 then 3.
REQ-041 rst_n asserted between grant and response -> rsp_valid never pulses; after release, req_valid=4'b1000 and 4'b0001 together -> grant 0.
REQ-042 Randomized req_valid, flush, stall 10k cycles -> at most one grant/cycle, every unflushed grant yields exactly one rsp at +2 with matching id, no requester starves beyond NUM_REQ grants.
